// File: rtl/game_pkg.sv
// game_pkg: game-state encodings and widths shared by the event generator and the FSM.
package game_pkg;
  typedef enum logic [1:0] {
    GAME_INITIAL = 2'b00,
    GAME_RUNNING = 2'b01,
    GAME_OVER    = 2'b10,
    GAME_SUCCESS = 2'b11
  } game_state_t;
  localparam int LIVES_W = 2;
endpackage

// File: rtl/game_event_gen_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-count debounce and one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DB_LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = DB_LIMIT > 1 ? $clog2(DB_LIMIT) : 1;
  localparam logic [CW-1:0] LIM = CW'(DB_LIMIT - 1);
  logic s1_q, s2_q, db_q, db_d, dbp_q, pulse_q;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    db_d  = (s2_q != db_q && cnt_q == LIM) ? ~db_q : db_q;
    cnt_d = (s2_q == db_q || cnt_q == LIM) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      dbp_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      cnt_q   <= cnt_d;
      pulse_q <= db_q & ~dbp_q;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/game_event_gen.sv
// game_event_gen: debounced start/restart pulses plus lives/over/success tracking for the game FSM.
// Optional post-hit invulnerability window and invul output when GAME_INVUL_EN is defined.
module game_event_gen
  import game_pkg::*;
#(
  parameter int DB_LIMIT     = 1_000_000,
  parameter int LIVES        = 3,
  parameter int X_W          = 12,
  parameter int FLAG_X       = 3000,
  parameter int INVUL_CYCLES = 2_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_start,
  input  logic               btn_restart,
  input  logic [1:0]         state,
  input  logic               hit,
  input  logic               fell,
  input  logic [X_W-1:0]     mario_x,
  output logic               start,
  output logic               restart,
  output logic               over,
  output logic               success,
`ifdef GAME_INVUL_EN
  output logic               invul,
`endif
  output logic [LIVES_W-1:0] lives
);
  game_state_t st;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic over_q, over_d, success_q, success_d, init, dmg_raw, dmg;
  assign st      = game_state_t'(state);
  assign init    = st == GAME_INITIAL;
  assign dmg_raw = (hit | fell) && st == GAME_RUNNING;
  btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_start (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_start), .pulse_o(start)
  );
  btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_restart (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_restart), .pulse_o(restart)
  );
`ifdef GAME_INVUL_EN
  localparam int IW = INVUL_CYCLES > 1 ? $clog2(INVUL_CYCLES) : 1;
  logic [IW-1:0] inv_q, inv_d;
  assign dmg = dmg_raw && inv_q == '0;
  always_comb
    inv_d = init ? '0 : dmg ? IW'(INVUL_CYCLES - 1) : (inv_q != '0) ? inv_q - 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= '0;
    else inv_q <= inv_d;
  end
  assign invul = inv_q != '0;
`else
  assign dmg = dmg_raw;
`endif
  // over wins whenever lives hit zero, including the very edge the flag is reached
  always_comb begin
    lives_d   = init ? LIVES_W'(LIVES) : (dmg && lives_q != '0) ? lives_q - 1'b1 : lives_q;
    over_d    = !init && (over_q || lives_d == '0);
    success_d = !init && !over_d &&
                (success_q || (st == GAME_RUNNING && mario_x >= X_W'(FLAG_X)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lives_q   <= LIVES_W'(LIVES);
      over_q    <= 1'b0;
      success_q <= 1'b0;
    end else begin
      lives_q   <= lives_d;
      over_q    <= over_d;
      success_q <= success_d;
    end
  end
  assign lives   = lives_q;
  assign over    = over_q;
  assign success = success_q;
endmodule

// File: tb/tb_game_event_gen.sv
// tb_game_event_gen: directed vectors for buttons, lives, over/success; invulnerability when GAME_INVUL_EN is defined.
module tb_game_event_gen;
  import game_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, btn_start, btn_restart, hit, fell, start, restart, over, success;
  logic [1:0] state, lives;
  logic [11:0] mario_x;
`ifdef GAME_INVUL_EN
  logic invul;
`endif
  int n_cmp = 0, n_bad = 0;
  game_event_gen #(
    .DB_LIMIT(4), .LIVES(3), .X_W(12), .FLAG_X(3000), .INVUL_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_restart(btn_restart),
    .state(state), .hit(hit), .fell(fell), .mario_x(mario_x),
    .start(start), .restart(restart), .over(over), .success(success),
`ifdef GAME_INVUL_EN
    .invul(invul),
`endif
    .lives(lives)
  );
  typedef struct {
    logic [1:0] st;
    logic h, f;
    logic [11:0] x;
    logic [1:0] e_lives;
    logic e_over, e_succ;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int np, pos, nr;
    tbl[0]  = '{GAME_INITIAL, 1, 0, 0,    3, 0, 0};
    tbl[1]  = '{GAME_RUNNING, 0, 0, 0,    3, 0, 0};
    tbl[2]  = '{GAME_RUNNING, 1, 1, 0,    2, 0, 0};
    tbl[3]  = '{GAME_RUNNING, 0, 0, 0,    2, 0, 0};
    tbl[4]  = '{GAME_RUNNING, 0, 1, 0,    1, 0, 0};
    tbl[5]  = '{GAME_RUNNING, 0, 0, 2999, 1, 0, 0};
    tbl[6]  = '{GAME_RUNNING, 1, 0, 3000, 0, 1, 0};
    tbl[7]  = '{GAME_RUNNING, 1, 0, 3000, 0, 1, 0};
    tbl[8]  = '{GAME_OVER,    1, 0, 0,    0, 1, 0};
    tbl[9]  = '{GAME_INITIAL, 0, 0, 0,    3, 0, 0};
    tbl[10] = '{GAME_RUNNING, 0, 0, 2999, 3, 0, 0};
    tbl[11] = '{GAME_RUNNING, 0, 0, 3000, 3, 0, 1};
    tbl[12] = '{GAME_RUNNING, 1, 0, 3000, 2, 0, 1};
    tbl[13] = '{GAME_SUCCESS, 1, 0, 0,    2, 0, 1};
    tbl[14] = '{GAME_INITIAL, 0, 0, 0,    3, 0, 0};
    rst_n = 1'b0; btn_start = 0; btn_restart = 0; hit = 0; fell = 0;
    state = GAME_INITIAL; mario_x = '0;
    step; step;
    chk("reset_lives", 16'(lives), 3);
    chk("reset_over", 16'(over), 0);
    chk("reset_success", 16'(success), 0);
    chk("reset_start", 16'(start), 0);
    chk("reset_restart", 16'(restart), 0);
    rst_n = 1'b1;
    step;
    // bouncing start press: 1-0-1, then held
    btn_start = 1; step;
    btn_start = 0; step;
    btn_start = 1;
    nr = 0;
    for (int k = 1; k <= 12; k++) begin
      step;
      chk($sformatf("start_at_%0d", k), 16'(start), 16'(k == 7));
      nr += int'(restart);
    end
    chk("restart_during_start", 16'(nr), 0);
    btn_start = 0;
    np = 0;
    for (int k = 1; k <= 12; k++) begin step; np += int'(start); end
    chk("start_release_pulses", 16'(np), 0);
    btn_restart = 1;
    np = 0; pos = 0;
    for (int k = 1; k <= 11; k++) begin
      step;
      if (restart) begin np++; pos = k; end
    end
    chk("restart_pulses", 16'(np), 1);
    chk("restart_pos", 16'(pos), 7);
    btn_restart = 0;
    np = 0;
    for (int k = 1; k <= 12; k++) begin step; np += int'(restart); end
    chk("restart_release_pulses", 16'(np), 0);
    // damage-separated vectors, idle gaps keep them outside any invulnerability window
    for (int i = 0; i < 15; i++) begin
      state = tbl[i].st; hit = tbl[i].h; fell = tbl[i].f; mario_x = tbl[i].x;
      step;
      hit = 0; fell = 0;
      chk($sformatf("v%0d_lives", i), 16'(lives), 16'(tbl[i].e_lives));
      chk($sformatf("v%0d_over", i), 16'(over), 16'(tbl[i].e_over));
      chk($sformatf("v%0d_success", i), 16'(success), 16'(tbl[i].e_succ));
      repeat (9) step;
    end
    mario_x = '0;
`ifndef GAME_INVUL_EN
    state = GAME_RUNNING;
    for (int h = 0; h < 4; h++) begin
      hit = 1; step; hit = 0;
      chk($sformatf("hit%0d_lives", h), 16'(lives), 16'(h < 3 ? 2 - h : 0));
      chk($sformatf("hit%0d_over", h), 16'(over), 16'(h >= 2));
      repeat (4) step;
    end
    state = GAME_INITIAL; step;
    chk("init_lives", 16'(lives), 3);
    chk("init_over", 16'(over), 0);
`else
    state = GAME_INITIAL; step;
    state = GAME_RUNNING;
    hit = 1; step; hit = 0;
    chk("inv_hit0_lives", 16'(lives), 2);
    chk("inv_hit0_invul", 16'(invul), 1);
    repeat (4) step;
    hit = 1; step; hit = 0;
    chk("inv_hit5_lives", 16'(lives), 2);
    repeat (3) step;
    hit = 1; step; hit = 0;
    chk("inv_hit9_lives", 16'(lives), 1);
    chk("inv_hit9_invul", 16'(invul), 1);
    repeat (2) step;
    rst_n = 0; #1;
    chk("inv_rst_invul", 16'(invul), 0);
    chk("inv_rst_lives", 16'(lives), 3);
    rst_n = 1;
    step;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
